ternary_psum_accumulator: RTL and testbench

TERNARY_PSUM_ACCUMULATOR -- requirements
Module: ternary_psum_accumulator

---
 rtl/ternary_psum_accumulator_pkg.sv | 11 +
 rtl/ternary_psum_accumulator_adder_tree.sv | 57 +++++
 rtl/ternary_psum_accumulator.sv | 92 +++++++++
 tb/tb_ternary_psum_accumulator.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ternary_psum_accumulator_pkg.sv
// ternary_psum_accumulator_pkg: shared clog2, FSM encoding and accumulator width default
package ternary_psum_accumulator_pkg;
   localparam int ACC_WIDTH_DEF = 24;
   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/ternary_psum_accumulator_adder_tree.sv
// ternary_adder_tree: pipelined binary adder tree, one register per level, side band carried alongside
module ternary_adder_tree
   import ternary_psum_accumulator_pkg::*;
#(
   parameter int N  = 100,
   parameter int DW = 8,
   parameter int AW = 24,
   parameter int SW = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*DW-1:0] data,
   input  logic            valid,
   input  logic [SW-1:0]   side,
   input  logic            enable,
   output logic [AW-1:0]   sum,
   output logic            sum_valid,
   output logic [SW-1:0]   sum_side
);
   localparam int D = clog2(N);
   localparam int L = 1 << D;
   logic [AW-1:0] lf [L];
   logic [AW-1:0] nd [1:L-1];
   logic [D-1:0]  vp;
   logic [SW-1:0] sp [D];
   // leaves beyond N are zero padding up to the next power of two
   for (genvar i = 0; i < L; i++) begin : g_leaf
      if (i < N) begin : g_in
         assign lf[i] = {{(AW-DW){data[i*DW+DW-1]}}, data[i*DW +: DW]};
      end else begin : g_pad
         assign lf[i] = '0;
      end
   end
   for (genvar k = 1; k < L; k++) begin : g_node
      if (2*k >= L) begin : g_bot
         always_ff @(posedge clk)
            if (enable) nd[k] <= lf[2*k-L] + lf[2*k+1-L];
      end else begin : g_mid
         always_ff @(posedge clk)
            if (enable) nd[k] <= nd[2*k] + nd[2*k+1];
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) vp <= '0;
      else if (enable) begin
         vp[0] <= valid;
         for (int j = 1; j < D; j++) vp[j] <= vp[j-1];
      end
   always_ff @(posedge clk)
      if (enable) begin
         sp[0] <= side;
         for (int j = 1; j < D; j++) sp[j] <= sp[j-1];
      end
   assign sum       = nd[1];
   assign sum_valid = vp[D-1];
   assign sum_side  = sp[D-1];
endmodule

// File: rtl/ternary_psum_accumulator.sv
// ternary_psum_accumulator: tree-summed ternary products accumulated across tiles, saturated output.
// Optional TERNARY_ACC_RELU_EN clamps negative results to 0 before saturation.
`ifndef Tn
`define Tn 4
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 5
`endif
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
`ifndef BIAS_WIDTH
`define BIAS_WIDTH 16
`endif
module ternary_psum_accumulator
   import ternary_psum_accumulator_pkg::*;
#(
   parameter int Tn            = `Tn,
   parameter int KERNEL_SIZE   = `KERNEL_SIZE,
   parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
   parameter int BIAS_WIDTH    = `BIAS_WIDTH,
   parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
   parameter int OUT_WIDTH     = `FEATURE_WIDTH
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] feature_in,
   input  logic                                             in_valid,
   input  logic                                             in_first,
   input  logic                                             in_last,
   input  logic [BIAS_WIDTH-1:0]                            bias_in,
   output logic                                             in_ready,
   output logic signed [OUT_WIDTH-1:0]                      out_data,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic                                             seq_err
);
   localparam int N  = Tn*KERNEL_SIZE*KERNEL_SIZE;
   localparam int SW = ACC_WIDTH + 2;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
   logic signed [ACC_WIDTH-1:0] sum, bias, acc, acc_next, res;
   logic signed [OUT_WIDTH-1:0] out_next;
   logic [SW-1:0] sum_side;
   logic sum_valid, first, last, stall, beat, load, err_next;
   state_t state, state_next;
   assign {first, last, bias} = sum_side;
   // only a finished pixel blocked by an unaccepted result freezes the pipe
   assign stall    = out_valid && !out_ready && sum_valid && last;
   assign in_ready = !stall;
   assign beat     = sum_valid && !stall;
   ternary_adder_tree #(.N(N), .DW(FEATURE_WIDTH), .AW(ACC_WIDTH), .SW(SW)) u_tree (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (feature_in),
      .valid     (in_valid),
      .side      ({in_first, in_last, {(ACC_WIDTH-BIAS_WIDTH){bias_in[BIAS_WIDTH-1]}}, bias_in}),
      .enable    (!stall),
      .sum       (sum),
      .sum_valid (sum_valid),
      .sum_side  (sum_side)
   );
   always_comb begin
      state_next = beat ? (last ? IDLE : ACCUM) : state;
      load       = state == IDLE || first;
      err_next   = beat && (state == IDLE ? !first : first);
      acc_next   = (load ? (first ? bias : '0) : acc) + sum;
`ifdef TERNARY_ACC_RELU_EN
      res        = acc_next < 0 ? '0 : acc_next;
`else
      res        = acc_next;
`endif
      out_next   = res > SAT_MAX ? SAT_MAX[OUT_WIDTH-1:0] : res < SAT_MIN ? SAT_MIN[OUT_WIDTH-1:0] : res[OUT_WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc       <= '0;
         seq_err   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         seq_err <= err_next;
         if (beat) acc <= acc_next;
         if (beat && last) begin
            out_valid <= 1'b1;
            out_data  <= out_next;
         end else if (out_ready) out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_ternary_psum_accumulator.sv
// tb_ternary_psum_accumulator: directed vectors with a scoreboard queue and a negedge monitor
module tb_ternary_psum_accumulator;
   localparam int N = 100, FW = 8, BW = 16, OW = 8, D = 7;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [N*FW-1:0] feature_in = '0;
   logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [BW-1:0] bias_in = '0;
   logic in_ready, out_valid, seq_err;
   logic signed [OW-1:0] out_data, held;
   int checks = 0, errors = 0, seq_cnt = 0, ready_low = 0;
   int q[$];
   bit hold = 1'b0;

   ternary_psum_accumulator #(.Tn(4), .KERNEL_SIZE(5), .FEATURE_WIDTH(FW), .BIAS_WIDTH(BW),
                              .ACC_WIDTH(24), .OUT_WIDTH(OW)) dut (
      .clk(clk), .rst_n(rst_n), .feature_in(feature_in), .in_valid(in_valid),
      .in_first(in_first), .in_last(in_last), .bias_in(bias_in), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   function automatic int model(input int s);
      int r;
      r = s;
`ifdef TERNARY_ACC_RELU_EN
      if (r < 0) r = 0;
`endif
      return r > 127 ? 127 : (r < -128 ? -128 : r);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         seq_cnt += int'(seq_err);
         if (!in_ready) ready_low++;
         if (hold) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_stable", int'(out_data), int'(held));
         end
         hold = out_valid && !out_ready;
         held = out_data;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %0d with no result pending", out_data);
            end else check("out_data", int'(out_data), q.pop_front());
         end
      end else hold = 1'b0;
   end

   task automatic send(input int v, input int cnt, input bit f, input bit l, input int b);
      int w;
      for (int i = 0; i < N; i++) feature_in[i*FW +: FW] = (i < cnt) ? FW'(v) : '0;
      in_first = f;
      in_last  = l;
      bias_in  = BW'(b);
      in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 300) begin
         @(posedge clk);
         w++;
      end
      #1 check("drain_pending", q.size(), 0);
   endtask

   initial begin
      int s0, r0, run, w;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_seq_err", int'(seq_err), 0);
      check("rst_out_data", int'(out_data), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      q.push_back(model(103));
      send(1, 100, 1, 1, 3);
      repeat (D-1) @(posedge clk);
      #1 check("latency_early", int'(out_valid), 0);
      @(posedge clk);
      #1 check("latency_d_plus_1", int'(out_valid), 1);
      drain();
      q.push_back(model(-300));
      send(-1, 100, 1, 0, 0);
      send(-1, 100, 0, 0, 0);
      send(-1, 100, 0, 1, 0);
      drain();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      s0 = seq_cnt;
      q.push_back(model(100));
      send(1, 100, 0, 1, 50);
      drain();
      check("seq_err_idle", seq_cnt - s0, 1);
      s0 = seq_cnt;
      q.push_back(model(8));
      send(1, 5, 1, 0, 9);
      send(1, 7, 1, 1, 1);
      drain();
      check("seq_err_accum", seq_cnt - s0, 1);
      s0 = seq_cnt;
      send(1, 10, 1, 0, 0);
      send(1, 10, 0, 0, 0);
      rst_n = 1'b0;
      #1 check("rst_mid_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (D+3) @(posedge clk);
      #1 check("rst_mid_no_out", int'(out_valid), 0);
      q.push_back(model(95));
      send(2, 50, 1, 1, -5);
      drain();
      check("rst_mid_seq_err", seq_cnt - s0, 0);
      r0 = ready_low;
      fork
         begin
            out_ready = 1'b0;
            repeat (20) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 8; i++) begin
               q.push_back(model(10*i - 20));
               send(1, 9*i, 1, 1, i - 20);
            end
         end
      join
      drain();
      check("in_ready_dropped", int'(ready_low > r0), 1);
      for (int i = 0; i < 6; i++) begin
         q.push_back(model(2*i + 1));
         send(1, i + 1, 1, 1, i);
      end
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 50) begin
         w++;
         @(negedge clk);
      end
      run = 0;
      for (int k = 0; k < 6; k++) begin
         if (out_valid) run++;
         @(negedge clk);
      end
      check("no_bubble_run", run, 6);
      drain();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
